// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Parametrised raster timing generator. Produces pixel-clock
//            enable, h/v counters, sync, display-enable, vblank, line/frame
//            strobes, a scanline-compare pulse and a completed-frame counter.
// Revision : 1.0  initial parametrised release
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 2,
    parameter int CNT_W     = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_i,
    input  logic [CNT_W-1:0]   line_cmp_i,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               display_on_o,
    output logic [CNT_W-1:0]   hpos_o,
    output logic [CNT_W-1:0]   vpos_o,
    output logic               pix_en_o,
    output logic               line_start_o,
    output logic               frame_start_o,
    output logic               vblank_o,
    output logic               line_irq_o,
    output logic [FRAME_W-1:0] frame_count_o
);

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]   hpos_q, hpos_d;
    logic [CNT_W-1:0]   vpos_q, vpos_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               hsync_q, vsync_q, display_on_q, vblank_q;
    logic               line_start_q, frame_start_q, line_irq_q;
    logic               pix_en;
    logic               h_wrap, v_wrap;
    logic               hs_act, vs_act;

    // Next-state counters: divider runs while enabled, raster advances on pix_en
    always_comb begin
        pix_en    = enable_i && (div_cnt_q == DIV_LAST);
        h_wrap    = (int'(hpos_q) == H_TOTAL - 1);
        v_wrap    = (int'(vpos_q) == V_TOTAL - 1);
        div_cnt_d = div_cnt_q;
        hpos_d    = hpos_q;
        vpos_d    = vpos_q;
        frame_d   = frame_q;
        if (enable_i) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        end
        if (pix_en) begin
            if (h_wrap) begin
                hpos_d = '0;
                if (v_wrap) begin
                    vpos_d  = '0;
                    frame_d = frame_q + FRAME_W'(1);
                end else begin
                    vpos_d = vpos_q + CNT_W'(1);
                end
            end else begin
                hpos_d = hpos_q + CNT_W'(1);
            end
        end
    end

    // Sync windows decoded from the next counter values so outputs never lag hpos/vpos
    always_comb begin
        hs_act = (int'(hpos_d) >= H_SYNC_BEG) && (int'(hpos_d) < H_SYNC_END);
        vs_act = (int'(vpos_d) >= V_SYNC_BEG) && (int'(vpos_d) < V_SYNC_END);
    end

    // State and registered outputs; strobes are single-cycle and only follow a real wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            frame_q       <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            display_on_q  <= 1'b1;
            vblank_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            line_irq_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_q       <= frame_d;
            hsync_q       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync_q       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            display_on_q  <= (int'(hpos_d) < H_ACTIVE) && (int'(vpos_d) < V_ACTIVE);
            vblank_q      <= (int'(vpos_d) >= V_ACTIVE);
            line_start_q  <= pix_en && h_wrap;
            frame_start_q <= pix_en && h_wrap && v_wrap;
            line_irq_q    <= pix_en && h_wrap && (vpos_d == line_cmp_i);
        end
    end

    assign pix_en_o      = pix_en;
    assign hpos_o        = hpos_q;
    assign vpos_o        = vpos_q;
    assign frame_count_o = frame_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign display_on_o  = display_on_q;
    assign vblank_o      = vblank_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign line_irq_o    = line_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Purpose  : Self-checking bench for video_timing_gen. Drives a default
//            640x480 instance and a tiny-raster instance from shared
//            enable/reset, compares every cycle with an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_video_timing_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [9:0] line_cmp_a = 10'd0;
    logic [9:0] line_cmp_b = 10'd0;

    logic       hsync_a, vsync_a, de_a, pe_a, ls_a, fs_a, vb_a, li_a;
    logic [9:0] hpos_a, vpos_a;
    logic [7:0] fc_a;
    logic       hsync_b, vsync_b, de_b, pe_b, ls_b, fs_b, vb_b, li_b;
    logic [9:0] hpos_b, vpos_b;
    logic [1:0] fc_b;

    always #5 clk = ~clk;

    video_timing_gen u_dut_a (
        .clk(clk), .reset(reset), .enable_i(enable), .line_cmp_i(line_cmp_a),
        .hsync_o(hsync_a), .vsync_o(vsync_a), .display_on_o(de_a),
        .hpos_o(hpos_a), .vpos_o(vpos_a), .pix_en_o(pe_a),
        .line_start_o(ls_a), .frame_start_o(fs_a), .vblank_o(vb_a),
        .line_irq_o(li_a), .frame_count_o(fc_a)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CLK_DIV(1), .CNT_W(10), .FRAME_W(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .enable_i(enable), .line_cmp_i(line_cmp_b),
        .hsync_o(hsync_b), .vsync_o(vsync_b), .display_on_o(de_b),
        .hpos_o(hpos_b), .vpos_o(vpos_b), .pix_en_o(pe_b),
        .line_start_o(ls_b), .frame_start_o(fs_b), .vblank_o(vb_b),
        .line_irq_o(li_b), .frame_count_o(fc_b)
    );

    // Timing descriptions of the two instances (index 0 = default, 1 = tiny)
    int c_ha[2], c_hf[2], c_hs[2], c_hb[2];
    int c_va[2], c_vf[2], c_vs[2], c_vb[2];
    int c_div[2], c_fw[2], c_hpol[2], c_vpol[2];

    // Model: number of enabled clocks since reset, plus expected strobes
    longint n[2];
    bit     ls_e[2], fs_e[2], li_e[2];

    int ncmp  = 0;
    int nfail = 0;
    int cnt_ls_a = 0;
    int cnt_fs_b = 0;

    function automatic int ht(int i);
        return c_ha[i] + c_hf[i] + c_hs[i] + c_hb[i];
    endfunction
    function automatic int vt(int i);
        return c_va[i] + c_vf[i] + c_vs[i] + c_vb[i];
    endfunction
    function automatic longint pix(int i);
        return n[i] / c_div[i];
    endfunction
    function automatic int exp_h(int i);
        return int'(pix(i) % ht(i));
    endfunction
    function automatic int exp_v(int i);
        return int'((pix(i) / ht(i)) % vt(i));
    endfunction
    function automatic int exp_fc(int i);
        return int'((pix(i) / (ht(i) * vt(i))) % (64'd1 << c_fw[i]));
    endfunction
    function automatic int lcmp(int i);
        return (i == 0) ? int'(line_cmp_a) : int'(line_cmp_b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input int expv);
        ncmp++;
        assert (obs === 32'(expv)) else begin
            nfail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_inst(input int i);
        logic [31:0] o_h, o_v, o_hs, o_vs, o_de, o_vb, o_pe, o_ls, o_fs, o_li, o_fc;
        int  h, v, hs_on, vs_on;
        string nm;
        if (i == 0) begin
            nm = "A";
            o_h = 32'(hpos_a); o_v = 32'(vpos_a); o_hs = 32'(hsync_a); o_vs = 32'(vsync_a);
            o_de = 32'(de_a); o_vb = 32'(vb_a); o_pe = 32'(pe_a); o_ls = 32'(ls_a);
            o_fs = 32'(fs_a); o_li = 32'(li_a); o_fc = 32'(fc_a);
        end else begin
            nm = "B";
            o_h = 32'(hpos_b); o_v = 32'(vpos_b); o_hs = 32'(hsync_b); o_vs = 32'(vsync_b);
            o_de = 32'(de_b); o_vb = 32'(vb_b); o_pe = 32'(pe_b); o_ls = 32'(ls_b);
            o_fs = 32'(fs_b); o_li = 32'(li_b); o_fc = 32'(fc_b);
        end
        h = exp_h(i);
        v = exp_v(i);
        hs_on = (h >= c_ha[i] + c_hf[i] && h < c_ha[i] + c_hf[i] + c_hs[i]) ? 1 : 0;
        vs_on = (v >= c_va[i] + c_vf[i] && v < c_va[i] + c_vf[i] + c_vs[i]) ? 1 : 0;
        check({nm, " hpos"}, o_h, h);
        check({nm, " vpos"}, o_v, v);
        check({nm, " frame_count"}, o_fc, exp_fc(i));
        check({nm, " hsync"}, o_hs, hs_on ? c_hpol[i] : 1 - c_hpol[i]);
        check({nm, " vsync"}, o_vs, vs_on ? c_vpol[i] : 1 - c_vpol[i]);
        check({nm, " display_on"}, o_de, (h < c_ha[i] && v < c_va[i]) ? 1 : 0);
        check({nm, " vblank"}, o_vb, (v >= c_va[i]) ? 1 : 0);
        check({nm, " pix_en"}, o_pe,
              (enable && (n[i] % c_div[i]) == c_div[i] - 1) ? 1 : 0);
        check({nm, " line_start"}, o_ls, int'(ls_e[i]));
        check({nm, " frame_start"}, o_fs, int'(fs_e[i]));
        check({nm, " line_irq"}, o_li, int'(li_e[i]));
    endtask

    // One clock: advance the model at the edge, then compare 1 time unit later
    task automatic tick();
        bit pe;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            ls_e[i] = 1'b0;
            fs_e[i] = 1'b0;
            li_e[i] = 1'b0;
            if (reset) begin
                n[i] = 0;
            end else if (enable) begin
                pe = ((n[i] % c_div[i]) == c_div[i] - 1);
                n[i] = n[i] + 1;
                if (pe && exp_h(i) == 0) begin
                    ls_e[i] = 1'b1;
                    fs_e[i] = (exp_v(i) == 0);
                    li_e[i] = (exp_v(i) == lcmp(i));
                end
            end
        end
        #1;
        check_inst(0);
        check_inst(1);
        if (ls_a) cnt_ls_a++;
        if (fs_b) cnt_fs_b++;
    endtask

    initial begin
        bit found;
        c_ha = '{640, 8}; c_hf = '{16, 2}; c_hs = '{96, 2}; c_hb = '{48, 2};
        c_va = '{480, 4}; c_vf = '{10, 1}; c_vs = '{2, 1};  c_vb = '{33, 1};
        c_div = '{2, 1};  c_fw = '{8, 2};  c_hpol = '{0, 1}; c_vpol = '{0, 0};
        n = '{0, 0};
        ls_e = '{0, 0}; fs_e = '{0, 0}; li_e = '{0, 0};

        // Reset held with enable high: reset must win
        reset = 1'b1; enable = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        line_cmp_a = 10'd1;
        line_cmp_b = 10'd3;

        // One default line: exactly one line_start; 16 tiny frames in the same window
        cnt_ls_a = 0; cnt_fs_b = 0;
        repeat (1600) tick();
        check("A line_start per 1600 clks", 32'(cnt_ls_a), 1);
        check("B frame_start per 1600 clks", 32'(cnt_fs_b), 16);

        // Freeze at hpos=300 for 50 clks, then resume
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            if (exp_h(0) == 300) found = 1'b1;
            else tick();
        end
        check("wait for A hpos 300", 32'(found), 1);
        enable = 1'b0;
        repeat (50) tick();
        enable = 1'b1;
        cnt_ls_a = 0;
        repeat (1650) tick();
        check("A line_start after freeze", 32'(cnt_ls_a), 1);

        // Compare line 0 (coincides with frame wrap) and an unreachable line
        line_cmp_b = 10'd0;
        repeat (300) tick();
        line_cmp_b = 10'd9;
        line_cmp_a = 10'd600;
        repeat (300) tick();

        // Reset mid-line on both instances
        repeat (37) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (20) tick();

        // Randomised enable gaps, compare-line changes and occasional resets
        for (int k = 0; k < 15000; k++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) line_cmp_b = 10'($urandom_range(0, 9));
            if ($urandom_range(0, 499) == 0) line_cmp_a = 10'($urandom_range(0, 4));
            reset = ($urandom_range(0, 2999) == 0);
            tick();
        end
        reset = 1'b0;
        enable = 1'b1;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
